adder_fnd_ctrl: RTL and testbench
=================================

Name: adder_fnd_ctrl

Overview:
Downstream display stage for the 4-bit ripple adder. It captures the adder result {cout, s[3:0]} (0..31) on a valid strobe and holds it. It converts the held value to decimal and drives a 4-digit, common-anode, multiplexed 7-segment display (Basys3-style FND). This gives a visible on-board check of adder results.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot (100 MHz / 100000 = 1 kHz per digit); legal range 1..2^20; the bench uses 4.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  capture strobe; sampled on rising clk edge
i_sum  in  4  adder sum s3..s0 (bit3 = s3)
i_cout  in  1  adder carry-out
o_value  out  5  held value {cout, sum}, registered
o_carry  out  1  held carry bit (o_value[4])
fnd_com  out  4  digit enables, active-low; bit0 = rightmost digit
fnd_data  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (rst_n=0, asynchronous, effective without a clock edge):
  - hold_reg=0, tick_cnt=0, digit_sel=0.
  - Outputs: o_value=0, o_carry=0, fnd_com=4'b1110, fnd_data=8'hC0.
- Registers: hold_reg[4:0], tick_cnt (width ceil(log2(TICK_DIV)), min 1), digit_sel[1:0].
- Capture:
  - i_valid=1 at an edge: hold_reg <= {i_cout, i_sum}.
  - i_valid=0: hold_reg keeps its value; input changes are ignored.
  - o_value = hold_reg, so it updates one edge after the capture.
- Scan counter:
  - tick_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - On the wrap edge, digit_sel increments mod 4 (0->1->2->3->0).
  - TICK_DIV=1: digit_sel advances every cycle.
- Digit state machine (4 states by digit_sel):
  - S0: fnd_com=1110, data=ones digit.
  - S1: fnd_com=1101, data=tens digit, blank if tens==0.
  - S2: fnd_com=1011, data=blank.
  - S3: fnd_com=0111, data='C' (8'hC6) if hold_reg[4]=1, else blank.
- fnd_com and fnd_data are a pure combinational decode of the registered digit_sel and hold_reg; they have no extra register stage.
- Decimal conversion, combinational, no divider:
  - tens = 3 if v>=30, 2 if v>=20, 1 if v>=10, else 0.
  - ones = v - 10*tens, 4-bit result.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, C=C6. dp is never lit.
- Simultaneous capture and digit advance on one edge: both take effect, and the newly selected digit shows the new value.
- Capture while a digit is selected: the shown segment pattern changes on the next edge; digit_sel is not disturbed.
- Reset asserted mid-scan: immediate return to reset values; scanning restarts at S0 with a full TICK_DIV slot after release.
- Only one fnd_com bit is ever low; all-high and multi-low patterns never occur.

Test Plan:
1. Reset and blanking (TICK_DIV=4):
   - Hold rst_n=0 -> fnd_com=1110, fnd_data=C0, o_value=0.
   - Release; after 4 clks -> fnd_com=1101, fnd_data=FF (tens blank).
   - After 4 more -> 1011/FF; then 0111/FF; then back to 1110/C0.
2. Max value: i_valid pulse with i_sum=4'b1111, i_cout=1 -> o_value=31, o_carry=1.
   - Scan shows: S0 data F9 ('1'), S1 B0 ('3'), S2 FF, S3 C6.
3. No carry: capture i_sum=9, i_cout=0 -> o_value=9.
   - Scan shows: S0 90, S1 FF, S2 FF, S3 FF.
4. Tens boundary: capture i_sum=4'b0101, i_cout=1 (21) -> S0 F9, S1 A4, S3 C6.
   - Then capture 4'b1010, i_cout=0 (10) -> S0 C0, S1 F9, S3 FF.
5. Hold and coincidence:
   - i_valid=0 while i_sum/i_cout toggle over all 32 combinations -> o_value and fnd_data unchanged.
   - i_valid=1 on the same edge as a digit wrap -> the new digit shows the new value one edge later.
6. Async reset mid-operation: while in S2 with hold=31, drop rst_n between clock edges.
   - Immediately: fnd_com=1110, fnd_data=C0, o_value=0.
   - After release: S0 lasts exactly 4 clks.

Source files
------------

// File: rtl/adder_fnd_ctrl.sv
// Display stage for the 4-bit ripple adder.
//
// Captures the adder result {cout, sum} (0..31) on a valid strobe, holds it, converts it to
// decimal and scans it onto a 4-digit common-anode 7-segment display (Basys3-style FND).
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_valid  - capture strobe, sampled on the rising clk edge
//   i_sum    - adder sum s3..s0
//   i_cout   - adder carry-out
//   o_value  - held value {cout, sum}
//   o_carry  - held carry bit (o_value[4])
//   fnd_com  - digit enables, active-low, bit0 = rightmost digit
//   fnd_data - segments, active-low, {dp,g,f,e,d,c,b,a}
module adder_fnd_ctrl #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [3:0] i_sum,
  input  logic       i_cout,
  output logic [4:0] o_value,
  output logic       o_carry,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegC     = 8'hC6;

  typedef enum logic [1:0] {StDig0, StDig1, StDig2, StDig3} digit_e;

  logic [4:0]       hold_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick_wrap;
  digit_e           digit_sel_q, digit_sel_d;

  logic [1:0] tens;
  logic [3:0] tens_x10;
  logic [3:0] ones;

  // Capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 5'd0;
    end else if (i_valid) begin
      hold_q <= {i_cout, i_sum};
    end
  end

  // Slot timer: one digit slot lasts TICK_DIV cycles.
  assign tick_wrap = (tick_cnt_q == TickMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick_wrap) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Digit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_q <= StDig0;
    end else begin
      digit_sel_q <= digit_sel_d;
    end
  end

  // Binary to decimal by comparison; value is at most 31 so tens is 0..3.
  always_comb begin
    tens = 2'd0;
    if (hold_q >= 5'd30) begin
      tens = 2'd3;
    end else if (hold_q >= 5'd20) begin
      tens = 2'd2;
    end else if (hold_q >= 5'd10) begin
      tens = 2'd1;
    end
  end

  // Only the low nibble of 10*tens is needed: the subtraction result fits in 4 bits, so
  // mod-16 arithmetic gives the exact ones digit (10, 20, 30 -> 10, 4, 14).
  always_comb begin
    tens_x10 = 4'd0;
    case (tens)
      2'd1:    tens_x10 = 4'd10;
      2'd2:    tens_x10 = 4'd4;
      2'd3:    tens_x10 = 4'd14;
      default: tens_x10 = 4'd0;
    endcase
  end

  assign ones = hold_q[3:0] - tens_x10;

  function automatic logic [7:0] seg7(input logic [3:0] digit);
    logic [7:0] seg;
    seg = SegBlank;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Next digit and output decode; outputs depend only on registered state.
  always_comb begin
    digit_sel_d = digit_sel_q;
    fnd_com     = 4'b1110;
    fnd_data    = SegBlank;
    unique case (digit_sel_q)
      StDig0: begin
        if (tick_wrap) digit_sel_d = StDig1;
        fnd_com  = 4'b1110;
        fnd_data = seg7(ones);
      end
      StDig1: begin
        if (tick_wrap) digit_sel_d = StDig2;
        fnd_com  = 4'b1101;
        fnd_data = (tens == 2'd0) ? SegBlank : seg7({2'b00, tens});
      end
      StDig2: begin
        if (tick_wrap) digit_sel_d = StDig3;
        fnd_com  = 4'b1011;
        fnd_data = SegBlank;
      end
      StDig3: begin
        if (tick_wrap) digit_sel_d = StDig0;
        fnd_com  = 4'b0111;
        fnd_data = hold_q[4] ? SegC : SegBlank;
      end
      default: begin
        digit_sel_d = StDig0;
        fnd_com     = 4'b1110;
        fnd_data    = SegBlank;
      end
    endcase
  end

  assign o_value = hold_q;
  assign o_carry = hold_q[4];

endmodule

// File: tb/tb_adder_fnd_ctrl.sv
module tb_adder_fnd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [3:0] i_sum;
  logic       i_cout;
  logic [4:0] o_value;
  logic       o_carry;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int n_checks;
  int n_fail;

  adder_fnd_ctrl #(
    .TICK_DIV(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_sum   (i_sum),
    .i_cout  (i_cout),
    .o_value (o_value),
    .o_carry (o_carry),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the first negedge at which the given digit has just become active.
  task automatic wait_entry(input logic [3:0] com, input string tag);
    int n;
    n = 0;
    while (fnd_com == com && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (fnd_com != com && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({tag, "_timeout"}, n, 0);
  endtask

  task automatic capture(input logic [3:0] sum, input logic cout);
    @(negedge clk);
    i_valid = 1'b1;
    i_sum   = sum;
    i_cout  = cout;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic scan_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    wait_entry(4'b1110, tag);
    check({tag, "_s0"}, fnd_data, e0);
    wait_entry(4'b1101, tag);
    check({tag, "_s1"}, fnd_data, e1);
    wait_entry(4'b1011, tag);
    check({tag, "_s2"}, fnd_data, e2);
    wait_entry(4'b0111, tag);
    check({tag, "_s3"}, fnd_data, e3);
  endtask

  logic [3:0] com_tab [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    com_tab[0] = 4'b1110;
    com_tab[1] = 4'b1101;
    com_tab[2] = 4'b1011;
    com_tab[3] = 4'b0111;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sum   = 4'd0;
    i_cout  = 1'b0;

    // 1. Reset and blank scan of value 0.
    #3;
    check("rst_com", fnd_com, 4'b1110);
    check("rst_data", fnd_data, 8'hC0);
    check("rst_value", o_value, 5'd0);
    check("rst_carry", o_carry, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("scan0_com", fnd_com, com_tab[((i + 1) / 4) % 4]);
      check("scan0_data", fnd_data, (((i + 1) / 4) % 4 == 0) ? 8'hC0 : 8'hFF);
    end

    // 2. Maximum value 31.
    capture(4'b1111, 1'b1);
    check("max_value", o_value, 5'd31);
    check("max_carry", o_carry, 1'b1);
    scan_check("max", 8'hF9, 8'hB0, 8'hFF, 8'hC6);

    // 3. No carry, 9.
    capture(4'd9, 1'b0);
    check("nine_value", o_value, 5'd9);
    check("nine_carry", o_carry, 1'b0);
    scan_check("nine", 8'h90, 8'hFF, 8'hFF, 8'hFF);

    // 4. Tens boundaries: 21 then 10.
    capture(4'b0101, 1'b1);
    check("v21_value", o_value, 5'd21);
    scan_check("v21", 8'hF9, 8'hA4, 8'hFF, 8'hC6);
    capture(4'b1010, 1'b0);
    check("v10_value", o_value, 5'd10);
    scan_check("v10", 8'hC0, 8'hF9, 8'hFF, 8'hFF);

    // 5a. Inputs ignored without the strobe.
    capture(4'd9, 1'b0);
    for (int i = 0; i < 32; i++) begin
      i_valid = 1'b0;
      {i_cout, i_sum} = 5'(i);
      @(negedge clk);
      check("hold_value", o_value, 5'd9);
    end
    i_sum  = 4'd0;
    i_cout = 1'b0;
    scan_check("hold", 8'h90, 8'hFF, 8'hFF, 8'hFF);

    // 5b. Capture of 17 on the same edge as the S3 -> S0 wrap.
    wait_entry(4'b0111, "coin");
    repeat (3) @(negedge clk);
    check("coin_pre_com", fnd_com, 4'b0111);
    check("coin_pre_data", fnd_data, 8'hFF);
    i_valid = 1'b1;
    i_sum   = 4'b0001;
    i_cout  = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check("coin_com", fnd_com, 4'b1110);
    check("coin_data", fnd_data, 8'hF8);
    check("coin_value", o_value, 5'd17);
    scan_check("v17", 8'hF8, 8'hF9, 8'hFF, 8'hC6);

    // 6. Asynchronous reset while S2 is shown with 31 held.
    capture(4'b1111, 1'b1);
    wait_entry(4'b1011, "arst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_com", fnd_com, 4'b1110);
    check("arst_data", fnd_data, 8'hC0);
    check("arst_value", o_value, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_slot_com", fnd_com, (i < 3) ? 4'b1110 : 4'b1101);
    end
    check("arst_s1_data", fnd_data, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
